mem_stage: RTL
==============

# mem_stage

Memory-access stage of the pipelined 16-bit CPU, sitting directly downstream of EX-2 and upstream of register-file writeback. It latches the EX-2 result and control bits into an internal EX/MEM register, performs loads and stores against the data memory over a variable-latency req/ack handshake, and stalls upstream while an access is outstanding. Its registered MEM/WB outputs drive `wb_reg_write`, `wb_rd` and `wb_data` into the regfile.

## Interface
- `DW`, 16: data and address width.
- `RW`, 4: register index width.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-low (asserted at 0).
- `ex_valid`  in  1  EX-2 presents a valid instruction this cycle.
- `ex_alu_result`  in  DW  ALU result; the memory address for loads and stores.
- `ex_store_data`  in  DW  store data (rs2).
- `ex_rd`  in  RW  destination register.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`  in  1 each  control bits.
- `mem_stall`  out  1  upstream must hold its outputs and `ex_valid`.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  DW  word address.
- `dmem_wdata`  out  DW  write data.
- `dmem_ack`  in  1  access complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata`  in  DW  read data.
- `wb_valid`  out  1  one instruction retires this cycle.
- `wb_reg_write`  out  1  regfile write enable.
- `wb_rd`  out  RW  regfile write index.
- `wb_data`  out  DW  regfile write data.

## Operation
- **EX/MEM capture.** On each edge with `mem_stall`=0, the EX/MEM register loads all `ex_*` fields plus `m_valid`=`ex_valid`. With `mem_stall`=1 it holds.
- **Op class.** A captured op is a memory op if `mem_read` or `mem_write` is set.
  - If both are set, write wins: the op is a store and no writeback occurs.
- **FSM states:**
  - IDLE:
    - On capture of a valid memory op -> ACCESS.
    - Otherwise stay in IDLE.
  - ACCESS:
    - `dmem_req`=1, `dmem_we`=`m_mem_write`.
    - `dmem_addr`/`dmem_wdata` come from the EX/MEM register and are held stable until ack.
    - On `dmem_ack`: -> IDLE, or stay in ACCESS if a new memory op is captured on the same edge.
- **Stall.** `mem_stall` = (state==ACCESS && !`dmem_ack`), combinational. ALU ops never stall.
- **MEM/WB load, ALU op** (`m_valid`, not memory, state IDLE):
  - `wb_valid`=1, `wb_reg_write`=`m_reg_write`, `wb_rd`=`m_rd`, `wb_data`=`m_alu_result`.
- **MEM/WB load, load** (ack edge):
  - `wb_valid`=1, `wb_reg_write`=`m_reg_write`.
  - `wb_data` = `dmem_rdata` if `m_mem_to_reg`, else `m_alu_result`.
- **MEM/WB load, store** (ack edge):
  - `wb_valid`=1, `wb_reg_write`=0, `wb_data`=`m_alu_result`.
- **Bubbles.** On any other edge, `wb_valid`=0 and `wb_reg_write`=0; `wb_rd`/`wb_data` hold their last value.
- **Boundary conditions:**
  - `dmem_ack` outside ACCESS is ignored.
  - `ex_valid`=0 captures a bubble and enters no state.
  - Back-to-back memory ops: on the ack edge, the next op is captured and ACCESS is re-entered with the new address, so `dmem_req` stays 1 with no gap.
  - Reset mid-access: `dmem_req` drops immediately and the in-flight op is discarded with no writeback. The memory side must tolerate an abandoned request.

## Timing
- Reset values: state=IDLE, `m_valid`=0, all EX/MEM fields 0.
  - Outputs: `mem_stall`=0, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `wb_valid`=0, `wb_reg_write`=0, `wb_rd`=0, `wb_data`=0.
- ALU op captured at edge N -> `wb_valid` high during cycle N+1 to N+2 (1-cycle latency, throughput 1/cycle).
- Memory op captured at edge N:
  - `dmem_req` is high from edge N.
  - With `dmem_ack` in cycle N+k (k≥0 after edge N), the writeback is registered at edge N+k+1.
  - Minimum latency is 1 cycle, identical to ALU ops, when memory acks in the first request cycle.
- `mem_stall` is high for exactly the ACCESS cycles before ack.
- `wb_valid` is a single-cycle pulse per retired instruction.

## Structure
- Shared package `cpu_pkg`:
  - `DW`/`RW` constants.
  - `mem_state_t` enum {IDLE, ACCESS}.
  - Struct type for the EX/MEM control bundle (reg_write, mem_read, mem_write, mem_to_reg, rd).
- One sub-module `pipe_mem_wb`: MEM/WB register with load-enable and async active-low reset, mirroring the existing pipe_* registers.
- The FSM, EX/MEM register and stall logic live in `mem_stage`.

## Test plan
- **ALU op.** Reset, then ALU op rd=3, result 0x1234 -> `wb_valid`=1, `wb_reg_write`=1, `wb_rd`=3, `wb_data`=0x1234 one cycle after capture; `mem_stall` never 1.
- **Load, latency 3.** Load addr 0x0040, memory acks after 3 cycles with 0xBEEF:
  - `dmem_req`=1, `dmem_we`=0, `dmem_addr`=0x0040 for 3 cycles; `mem_stall`=1 for 2 cycles.
  - Then `wb_data`=0xBEEF, `wb_rd` as issued.
- **Store, zero-wait.** Store 0x00AA to 0x0010 with same-cycle ack -> `dmem_we`=1, `dmem_wdata`=0x00AA, `mem_stall`=0 throughout, `wb_valid`=1, `wb_reg_write`=0.
- **Back-to-back.** Load, load, ALU with ack delay 1 -> `dmem_req` continuous across both loads; three `wb_valid` pulses in program order; `ex_*` held correctly while stalled.
- **Reset mid-access.** Assert `rst`=0 mid-ACCESS -> `dmem_req`, `mem_stall` and `wb_valid` go 0 asynchronously; no writeback after release; a later ack is ignored.
- **Both read and write set.** Op with `mem_read`=`mem_write`=1 -> treated as a store, `wb_reg_write`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: datapath widths, memory-stage FSM encoding and the
// EX/MEM control bundle carried alongside the ALU result.
package cpu_pkg;

   localparam int DW = 16;
   localparam int RW = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic          reg_write;
      logic          mem_read;
      logic          mem_write;
      logic          mem_to_reg;
      logic [RW-1:0] rd;
   } exmem_ctrl_t;

   function automatic logic is_mem_op(input exmem_ctrl_t c);
      return c.mem_read | c.mem_write;
   endfunction

endpackage

// File: rtl/pipe_mem_wb.sv
// MEM/WB pipeline register. A load captures a retiring instruction; any other
// edge inserts a bubble while index and data keep their last value.
module pipe_mem_wb
   import cpu_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          next_valid,
   input  logic          next_reg_write,
   input  logic [RW-1:0] next_rd,
   input  logic [DW-1:0] next_data,
   output logic          valid,
   output logic          reg_write,
   output logic [RW-1:0] rd,
   output logic [DW-1:0] data
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid     <= 1'b0;
         reg_write <= 1'b0;
         rd        <= '0;
         data      <= '0;
      end else if (load) begin
         valid     <= next_valid;
         reg_write <= next_reg_write;
         rd        <= next_rd;
         data      <= next_data;
      end else begin
         valid     <= 1'b0;
         reg_write <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, load/store FSM over a variable-latency
// req/ack data-memory port, upstream stall, and the MEM/WB register.
module mem_stage
   import cpu_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          ex_valid,
   input  logic [DW-1:0] ex_alu_result,
   input  logic [DW-1:0] ex_store_data,
   input  logic [RW-1:0] ex_rd,
   input  logic          ex_reg_write,
   input  logic          ex_mem_read,
   input  logic          ex_mem_write,
   input  logic          ex_mem_to_reg,
   output logic          mem_stall,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [DW-1:0] dmem_addr,
   output logic [DW-1:0] dmem_wdata,
   input  logic          dmem_ack,
   input  logic [DW-1:0] dmem_rdata,
   output logic          wb_valid,
   output logic          wb_reg_write,
   output logic [RW-1:0] wb_rd,
   output logic [DW-1:0] wb_data
);

   mem_state_t  state;
   logic        m_valid;
   exmem_ctrl_t m_ctrl;
   logic [DW-1:0] m_alu_result;
   logic [DW-1:0] m_store_data;

   logic in_access;
   logic capture;
   logic ex_is_mem;
   logic acked;
   logic alu_retire;
   logic wb_load;
   logic wb_next_reg_write;
   logic [DW-1:0] wb_next_data;

   assign in_access = (state == ACCESS);
   assign mem_stall = in_access & ~dmem_ack;
   assign capture   = ~mem_stall;
   assign ex_is_mem = ex_valid & (ex_mem_read | ex_mem_write);

   // The state always describes the op held in EX/MEM, so both advance together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         m_valid      <= 1'b0;
         m_ctrl       <= '0;
         m_alu_result <= '0;
         m_store_data <= '0;
      end else if (capture) begin
         state             <= ex_is_mem ? ACCESS : IDLE;
         m_valid           <= ex_valid;
         m_ctrl.reg_write  <= ex_reg_write;
         m_ctrl.mem_read   <= ex_mem_read;
         m_ctrl.mem_write  <= ex_mem_write;
         m_ctrl.mem_to_reg <= ex_mem_to_reg;
         m_ctrl.rd         <= ex_rd;
         m_alu_result      <= ex_alu_result;
         m_store_data      <= ex_store_data;
      end
   end

   assign dmem_req   = in_access;
   assign dmem_we    = in_access & m_ctrl.mem_write;
   assign dmem_addr  = m_alu_result;
   assign dmem_wdata = m_store_data;

   // A set mem_write makes the op a store even if mem_read is also set.
   assign acked             = in_access & dmem_ack;
   assign alu_retire        = m_valid & ~is_mem_op(m_ctrl) & ~in_access;
   assign wb_load           = alu_retire | acked;
   assign wb_next_reg_write = m_ctrl.reg_write & ~m_ctrl.mem_write;
   assign wb_next_data      = (acked & ~m_ctrl.mem_write & m_ctrl.mem_to_reg)
                              ? dmem_rdata : m_alu_result;

   pipe_mem_wb u_mem_wb (
      .clk            (clk),
      .rst            (rst),
      .load           (wb_load),
      .next_valid     (1'b1),
      .next_reg_write (wb_next_reg_write),
      .next_rd        (m_ctrl.rd),
      .next_data      (wb_next_data),
      .valid          (wb_valid),
      .reg_write      (wb_reg_write),
      .rd             (wb_rd),
      .data           (wb_data)
   );

endmodule
